post_code_capture: RTL and testbench

//  Snoops CPU I/O writes to the POST diagnostic port (0x80). Queues each written

---
 rtl/postcode_pkg.sv | 11 +
 rtl/postcode_fifo.sv | 47 ++++
 rtl/post_code_capture.sv | 117 +++++++++++
 tb/tb_post_code_capture.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/postcode_pkg.sv
// Shared types and constants for the POST code capture block.
package postcode_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [9:0] POSTCODE_PORT = 10'h080;

endpackage

// File: rtl/postcode_fifo.sv
// DEPTH x 8 circular queue of POST codes; when full, a push without a pop
// overwrites the oldest entry so the newest codes are always kept.
module postcode_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       ovf_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        rd_adv;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign ovf_pulse = push && full && !do_pop;
  // An overwrite drops the oldest code, so the read side moves too.
  assign rd_adv    = do_pop || ovf_pulse;
  assign dout      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_adv) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/post_code_capture.sv
// Snoops I/O writes to the POST port and shows each code for HOLD_CYCLES clocks.
// Optional sticky overflow flag: define POSTCODE_OVERFLOW_EN.
module post_code_capture
  import postcode_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] PORT_ADDR   = ADDR_W'(POSTCODE_PORT),
  parameter int                DEPTH       = 8,
  parameter int                HOLD_CYCLES = 4_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_wr,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_data,
  output logic [7:0]        value,
  output logic              holding,
  output logic              overflow
);

  localparam int            TW         = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

  logic          io_wr_q;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          q_empty;
  logic          q_full_unused;
  logic          ovf_pulse;
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [7:0]    value_q;
  logic [7:0]    value_d;

  // One push per strobe: only the rising edge of io_wr counts.
  assign push = io_wr && !io_wr_q && (io_addr == PORT_ADDR);

  postcode_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (io_data),
    .dout      (head),
    .empty     (q_empty),
    .full      (q_full_unused),
    .ovf_pulse (ovf_pulse)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    value_d = value_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          value_d = head;
          timer_d = TIMER_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (!q_empty) begin
          pop     = 1'b1;
          value_d = head;
          timer_d = TIMER_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_wr_q <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      value_q <= 8'h00;
    end else begin
      io_wr_q <= io_wr;
      state_q <= state_d;
      timer_q <= timer_d;
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign holding = (state_q == HOLD);

`ifdef POSTCODE_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_q <= 1'b0;
    else if (ovf_pulse) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  logic ovf_unused;

  assign ovf_unused = ovf_pulse;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_post_code_capture.sv
// Directed bench for post_code_capture with DEPTH=4, HOLD_CYCLES=4.
module tb_post_code_capture;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
`ifdef POSTCODE_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       io_wr   = 1'b0;
  logic [9:0] io_addr = 10'h000;
  logic [7:0] io_data = 8'h00;
  logic [7:0] value;
  logic       holding;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp4 [8];

  post_code_capture #(
    .ADDR_W      (10),
    .PORT_ADDR   (10'h080),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_data  (io_data),
    .value    (value),
    .holding  (holding),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle strobe; returns just after the edge that samples it.
  task automatic write(input logic [9:0] addr, input logic [7:0] data);
    io_addr = addr;
    io_data = data;
    io_wr   = 1'b1;
    tick();
    io_wr   = 1'b0;
  endtask

  initial begin
    exp4 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h60, 8'h70, 8'h80, 8'h90};

    // 1: reset state, single write, hold length
    #1 rst = 1'b1;
    #2;
    check("rst_value", value, 8'h00);
    check("rst_holding", 8'(holding), 8'h00);
    check("rst_overflow", 8'(overflow), 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    write(10'h080, 8'h3C);
    check("t1_push_edge_value", value, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t1_value_%0d", i), value, 8'h3C);
      check($sformatf("t1_holding_%0d", i), 8'(holding), (i <= 4) ? 8'h01 : 8'h00);
    end

    // 2: long strobe gives one code; other addresses ignored
    io_addr = 10'h080;
    io_data = 8'h11;
    io_wr   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) begin
        check("t2_value", value, 8'h11);
        check("t2_holding", 8'(holding), 8'h01);
      end
    end
    check("t2_single_code", 8'(holding), 8'h00);
    io_wr = 1'b0;
    write(10'h081, 8'h22);
    tick();
    tick();
    write(10'h280, 8'h33);
    tick();
    tick();
    check("t2_other_addr_value", value, 8'h11);
    check("t2_other_addr_holding", 8'(holding), 8'h00);

    // 3: back-to-back codes, each held 4 cycles with no gap
    io_addr = 10'h080;
    for (int k = 0; k < 14; k++) begin
      io_wr   = (k < 6) && (k % 2 == 0);
      io_data = 8'(k / 2 + 1);
      tick();
      check($sformatf("t3_value_k%0d", k), value,
            (k == 0) ? 8'h11 : (k <= 4) ? 8'h01 : (k <= 8) ? 8'h02 : 8'h03);
      check($sformatf("t3_holding_k%0d", k), 8'(holding),
            ((k >= 1) && (k <= 12)) ? 8'h01 : 8'h00);
    end
    io_wr = 1'b0;

    // 4: sustained writes overflow the queue; oldest queued code (0x50) lost
    for (int k = 0; k < 34; k++) begin
      io_wr   = (k <= 16) && (k % 2 == 0);
      io_data = 8'((k / 2 + 1) * 16);
      tick();
      if ((k >= 1) && (k <= 29) && ((k - 1) % 4 == 0))
        check($sformatf("t4_value_k%0d", k), value, exp4[(k - 1) / 4]);
      if (k == 15) check("t4_no_ovf_yet", 8'(overflow), 8'h00);
      if (k == 32) check("t4_last_holding", 8'(holding), 8'h01);
    end
    io_wr = 1'b0;
    check("t4_final_value", value, 8'h90);
    check("t4_final_holding", 8'(holding), 8'h00);
    check("t4_overflow", 8'(overflow), 8'(OVF_EN));

    // 5: reset mid-hold with two codes queued
    write(10'h080, 8'hA1);
    tick();
    write(10'h080, 8'hA2);
    tick();
    write(10'h080, 8'hA3);
    check("t5_pre_rst_value", value, 8'hA1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_value", value, 8'h00);
    check("t5_rst_holding", 8'(holding), 8'h00);
    check("t5_rst_overflow", 8'(overflow), 8'h00);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t5_quiet_holding_%0d", i), 8'(holding), 8'h00);
    end
    check("t5_quiet_value", value, 8'h00);

    // 6: push on the same edge as the expiry pop, one entry queued
    write(10'h080, 8'hB1);
    tick();
    write(10'h080, 8'hB2);
    tick();
    tick();
    check("t6_k4_value", value, 8'hB1);
    write(10'h080, 8'hB3);
    check("t6_k5_value", value, 8'hB2);
    check("t6_k5_holding", 8'(holding), 8'h01);
    for (int k = 6; k <= 13; k++) begin
      tick();
      if (k == 8)  check("t6_k8_value", value, 8'hB2);
      if (k == 9)  check("t6_k9_value", value, 8'hB3);
      if (k == 12) check("t6_k12_holding", 8'(holding), 8'h01);
    end
    check("t6_k13_holding", 8'(holding), 8'h00);
    check("t6_k13_value", value, 8'hB3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
